fm_matrix_mac_sequencer: RTL and testbench

- Read-side initiator for the dual-read register file that holds the FM operator matrix.
- On a start pulse it walks every destination operator d and issues paired reads each cycle: modulation gain on port 0, source operator output on port 1.
- It multiply-accumulates each pair and writes the saturated modulation sum for d back into the same register file.
- It sits between the per-sample control FSM and the register file, once per audio sample.

---
 rtl/fm_matrix_mac_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fm_matrix_mac_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fm_matrix_mac_sequencer.sv
// FM operator-matrix MAC sequencer: walks every destination operator, reads gain/output pairs
// from the dual-read register file, accumulates Q1.15 products and writes back saturated sums.
module fm_matrix_mac_sequencer #(
    parameter int DW        = 16,
    parameter int AW        = 12,
    parameter int NOPS      = 4,
    parameter int GAIN_BASE = 0,
    parameter int OUT_BASE  = 64,
    parameter int MOD_BASE  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rden,
    output logic [AW-1:0]     r_addr0,
    output logic [AW-1:0]     r_addr1,
    input  logic [2*DW-1:0]   r_data,
    output logic              wren,
    output logic [AW-1:0]     w_addr,
    output logic [DW-1:0]     w_data
);

    localparam int LW   = $clog2(NOPS);
    localparam int ACCW = DW + LW + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [LW-1:0]           d_r, d_s, s_r, s_s;
    logic signed [ACCW-1:0]  acc_r, acc_s;
    logic                    valid_r;
    logic signed [2*DW-1:0]  prod_s, shifted_s;
    logic signed [ACCW-1:0]  term_s;
    logic                    busy_r, done_r, rden_r, wren_r;
    logic [AW-1:0]           r_addr0_r, r_addr1_r, w_addr_r;
    logic [DW-1:0]           w_data_r;

    // Clamp the wide accumulator into the signed DW-bit result range.
    function automatic logic [DW-1:0] sat_fn(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] hi;
        logic signed [ACCW-1:0] lo;
        hi = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        lo = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        if (a > hi) begin
            sat_fn = hi[DW-1:0];
        end else if (a < lo) begin
            sat_fn = lo[DW-1:0];
        end else begin
            sat_fn = a[DW-1:0];
        end
    endfunction

    // Q1.(DW-1) product rescaled by flooring arithmetic shift.
    assign prod_s    = signed'(r_data[DW-1:0]) * signed'(r_data[2*DW-1:DW]);
    assign shifted_s = prod_s >>> (DW-1);
    assign term_s    = signed'(shifted_s[ACCW-1:0]);

    // Next-state, counter and accumulator logic.
    always_comb begin
        state_s = state_r;
        d_s     = d_r;
        s_s     = s_r;
        if (valid_r) begin
            acc_s = acc_r + term_s;
        end else begin
            acc_s = acc_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    d_s     = '0;
                    s_s     = '0;
                    acc_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_s = s_r + LW'(1);
                if (s_r == LW'(NOPS-1)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: state_s = ST_WRITE;
            ST_WRITE: begin
                acc_s = '0;
                s_s   = '0;
                if (d_r == LW'(NOPS-1)) begin
                    state_s = ST_DONE;
                end else begin
                    d_s     = d_r + LW'(1);
                    state_s = ST_RUN;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State, counters and MAC pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            d_r     <= '0;
            s_r     <= '0;
            acc_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            d_r     <= d_s;
            s_r     <= s_s;
            acc_r   <= acc_s;
            valid_r <= rden_r;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rden_r    <= 1'b0;
            wren_r    <= 1'b0;
            r_addr0_r <= '0;
            r_addr1_r <= '0;
            w_addr_r  <= '0;
            w_data_r  <= '0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
            rden_r <= (state_s == ST_RUN);
            wren_r <= (state_s == ST_WRITE);
            if (state_s == ST_RUN) begin
                r_addr0_r <= AW'(GAIN_BASE) + AW'({d_s, s_s});
                r_addr1_r <= AW'(OUT_BASE) + AW'(s_s);
            end else begin
                r_addr0_r <= r_addr0_r;
                r_addr1_r <= r_addr1_r;
            end
            if (state_s == ST_WRITE) begin
                w_addr_r <= AW'(MOD_BASE) + AW'(d_s);
                w_data_r <= sat_fn(acc_s);
            end else begin
                w_addr_r <= w_addr_r;
                w_data_r <= w_data_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rden    = rden_r;
    assign wren    = wren_r;
    assign r_addr0 = r_addr0_r;
    assign r_addr1 = r_addr1_r;
    assign w_addr  = w_addr_r;
    assign w_data  = w_data_r;

endmodule

// File: tb/tb_fm_matrix_mac_sequencer.sv
// Directed bench for fm_matrix_mac_sequencer: register-file model, timing and result checks.
module tb_fm_matrix_mac_sequencer;

    localparam int DW = 16;
    localparam int AW = 12;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           busy, done, rden, wren;
    logic [AW-1:0]  r_addr0, r_addr1, w_addr;
    logic [2*DW-1:0] r_data;
    logic [DW-1:0]  w_data;

    logic [15:0]    mem [0:255];
    logic [15:0]    got [0:3];
    int             n_wr;
    int             n_done;
    int             n_vec = 0;
    int             n_err = 0;

    fm_matrix_mac_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rden    (rden),
        .r_addr0 (r_addr0),
        .r_addr1 (r_addr1),
        .r_data  (r_data),
        .wren    (wren),
        .w_addr  (w_addr),
        .w_data  (w_data)
    );

    always #5 clk = ~clk;

    // Register file read side: data valid the cycle after rden.
    always @(posedge clk) begin
        if (rden) begin
            r_data <= {mem[r_addr1[7:0]], mem[r_addr0[7:0]]};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_ctl(input int c);
        logic b, dn, rd, wr;
        b  = (c >= 1 && c <= 25);
        dn = (c == 25);
        rd = (c >= 1 && c <= 22 && (c % 6) >= 1 && (c % 6) <= 4);
        wr = (c >= 6 && c <= 24 && (c % 6) == 0);
        return {b, dn, rd, wr};
    endfunction

    task automatic load(input logic [15:0] g_diag, input logic [15:0] g_off,
                        input logic [15:0] o0, input logic [15:0] o1,
                        input logic [15:0] o2, input logic [15:0] o3);
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 4; s++) begin
                mem[d*4+s] = (d == s) ? g_diag : g_off;
            end
        end
        mem[64] = o0;
        mem[65] = o1;
        mem[66] = o2;
        mem[67] = o3;
    endtask

    // Starts one computation in the current cycle and observes cycles 1..26.
    task automatic run_seq(input bit extra, input bit timing);
        int c;
        n_wr   = 0;
        n_done = 0;
        for (int i = 0; i < 4; i++) got[i] = 16'hDEAD;
        for (int k = 0; k < 26; k++) begin
            start = (k == 0) || (extra && (k == 3 || k == 10 || k == 25));
            tick();
            start = 1'b0;
            c = k + 1;
            if (timing) begin
                check_eq($sformatf("ctl_c%0d", c), {28'd0, busy, done, rden, wren}, {28'd0, exp_ctl(c)});
                if (c == 2) check_eq("raddr_c2", {8'd0, r_addr0, r_addr1}, {8'd0, 12'd1, 12'd65});
                if (c == 5) check_eq("raddr_hold_c5", {8'd0, r_addr0, r_addr1}, {8'd0, 12'd3, 12'd67});
            end
            if (rden && wren) check_eq("rden_wren_excl", 32'd1, 32'd0);
            if (wren) begin
                if (n_wr < 4) begin
                    check_eq($sformatf("w_addr%0d", n_wr), {20'd0, w_addr}, 32'd128 + n_wr);
                    got[n_wr] = w_data;
                end
                n_wr++;
            end
            if (done) n_done++;
        end
        check_eq("write_count", n_wr, 32'd4);
        check_eq("done_count", n_done, 32'd1);
    endtask

    task automatic check_res(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        check_eq({tag, "_mod0"}, {16'd0, got[0]}, {16'd0, e0});
        check_eq({tag, "_mod1"}, {16'd0, got[1]}, {16'd0, e1});
        check_eq({tag, "_mod2"}, {16'd0, got[2]}, {16'd0, e2});
        check_eq({tag, "_mod3"}, {16'd0, got[3]}, {16'd0, e3});
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ctl"}, {28'd0, busy, done, rden, wren}, 32'd0);
        check_eq({tag, "_raddr"}, {8'd0, r_addr0, r_addr1}, 32'd0);
        check_eq({tag, "_wr"}, {4'd0, w_addr, w_data}, 32'd0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        check_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        load(16'h7FFF, 16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
        run_seq(1'b0, 1'b1);
        check_res("ident", 16'h0FFF, 16'h1FFF, 16'h2FFF, 16'h3FFF);

        load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_seq(1'b0, 1'b1);
        check_res("possat", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);

        load(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_seq(1'b0, 1'b0);
        check_res("negsat", 16'h8000, 16'h8000, 16'h8000, 16'h8000);

        load(16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        mem[2*4+1] = 16'h8000;
        run_seq(1'b1, 1'b1);
        check_res("single", 16'h0000, 16'h0000, 16'h7FFF, 16'h0000);
        run_seq(1'b0, 1'b1);
        check_res("restart", 16'h0000, 16'h0000, 16'h7FFF, 16'h0000);

        // Mid-run reset at cycle 9, then a clean run from d=0.
        load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 9; k++) tick();
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (wren || rden || busy) seen++;
        end
        check_eq("post_reset_quiet", seen, 32'd0);
        load(16'h7FFF, 16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
        run_seq(1'b0, 1'b1);
        check_res("after_reset", 16'h0FFF, 16'h1FFF, 16'h2FFF, 16'h3FFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
